// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller.
// State encodings and default timing limits used by the controller and its wait counter.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int         TIMEOUT_CYCLES_DEF = 16;
   localparam int         CNT_W_DEF          = 5;
   localparam logic [3:0] BE_WORD            = 4'hF;

endpackage

// File: rtl/mem_wait_counter.sv
// Up-counter that tracks cycles spent waiting for mem_ack.
// The terminal count flags the last cycle before the access is abandoned.
module mem_wait_counter #(
   parameter int CNT_W          = 5,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(negedge clk) begin
      if (Reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory sequencer: issues one request per load/store, stalls the
// pipeline until ack or timeout, and captures load data for MEM/WB.
//
// state | meaning
// IDLE  | no access outstanding; a valid memory op launches a request
// REQ   | mem_req high, waiting for mem_ack or the wait limit
// DONE  | access finished; pipeline advances for one cycle, no new request
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        Overflow_in,
   input  logic [31:0] Addr_in,
   input  logic [31:0] WrData_in,
   input  logic [3:0]  ByteEn_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        Stall,
   output logic        MemWb_bubble,
   output logic [31:0] Data_out,
   output logic        Timeout_err
);

   mem_state_t state_q;
   mem_state_t state_d;
   logic       mem_op;
   logic       stall_c;
   logic       cnt_clear;
   logic       cnt_en;
   logic       cnt_tc;

   // A store with no enabled lanes is a no-op, and overflowed instructions never touch memory.
   assign mem_op = (MemRead_in | (MemWrite_in & (|ByteEn_in))) & ~Overflow_in;

   assign cnt_clear = (state_q != REQ) | mem_ack | cnt_tc;
   assign cnt_en    = (state_q == REQ) & ~mem_ack & ~cnt_tc;

   mem_wait_counter #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_counter (
      .clk    (clk),
      .Reset  (Reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .tc     (cnt_tc)
   );

   always_ff @(negedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               state_d = REQ;
               stall_c = 1'b1;
            end
         end
         REQ: begin
            stall_c = 1'b1;
            if (mem_ack || cnt_tc) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reset overrides a stall so the pipeline registers see a clean reset cycle.
   assign Stall        = stall_c & ~Reset;
   assign MemWb_bubble = Stall;

   always_ff @(negedge clk) begin
      if (Reset) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         Data_out    <= '0;
         Timeout_err <= 1'b0;
      end else if (state_q == IDLE) begin
         if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= ~MemRead_in;
            mem_addr  <= Addr_in & 32'hFFFF_FFFC;
            mem_wdata <= WrData_in;
            mem_be    <= MemRead_in ? BE_WORD : ByteEn_in;
         end
      end else if (state_q == REQ) begin
         if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
               Data_out <= mem_rdata;
            end
         end else if (cnt_tc) begin
            mem_req     <= 1'b0;
            Data_out    <= '0;
            Timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, suppression, timeout,
// back-to-back accesses and reset during an outstanding request.
module tb_mem_access_ctrl;

   logic        clk;
   logic        Reset;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic        Overflow_in;
   logic [31:0] Addr_in;
   logic [31:0] WrData_in;
   logic [3:0]  ByteEn_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        Stall;
   logic        MemWb_bubble;
   logic [31:0] Data_out;
   logic        Timeout_err;

   int total;
   int bad;
   int stalls;
   int reqs;

   mem_access_ctrl dut (
      .clk          (clk),
      .Reset        (Reset),
      .MemRead_in   (MemRead_in),
      .MemWrite_in  (MemWrite_in),
      .Overflow_in  (Overflow_in),
      .Addr_in      (Addr_in),
      .WrData_in    (WrData_in),
      .ByteEn_in    (ByteEn_in),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .Stall        (Stall),
      .MemWb_bubble (MemWb_bubble),
      .Data_out     (Data_out),
      .Timeout_err  (Timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs the access whose inputs are already driven for the current cycle.
   // ack_wait<0 never acks. Ends at the mid-point of the first non-stalled cycle.
   task automatic do_access(input int ack_wait, input logic [31:0] rdata,
                            output int n_stall, output int n_req);
      int  cyc;
      bit  fin;
      n_stall = 0;
      n_req   = 0;
      cyc     = 0;
      fin     = 0;
      while (!fin) begin
         @(posedge clk);
         if (cyc == 0) chk("no_req_before_launch", {31'd0, mem_req}, 32'd0);
         if (MemWb_bubble !== Stall) chk("bubble_eq_stall", {31'd0, MemWb_bubble}, {31'd0, Stall});
         if (Stall === 1'b1) begin
            n_stall++;
            if (mem_req === 1'b1) n_req++;
         end
         if (Stall !== 1'b1) begin
            fin = 1;
         end else if (cyc >= 40) begin
            chk("access_cycle_bound", 32'd0, 32'd1);
            fin = 1;
         end else begin
            @(negedge clk);
            #1;
            cyc++;
            mem_ack   = (ack_wait >= 0) && (cyc == 1 + ack_wait);
            mem_rdata = rdata;
         end
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      Reset       = 1'b1;
      MemRead_in  = 1'b0;
      MemWrite_in = 1'b0;
      Overflow_in = 1'b0;
      Addr_in     = '0;
      WrData_in   = '0;
      ByteEn_in   = '0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;

      // reset state
      repeat (2) @(negedge clk);
      @(posedge clk);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_data_out", Data_out, 32'd0);
      chk("rst_timeout", {31'd0, Timeout_err}, 32'd0);
      chk("rst_stall", {31'd0, Stall}, 32'd0);

      // load, ack in first REQ cycle
      @(negedge clk); #1;
      Reset      = 1'b0;
      MemRead_in = 1'b1;
      Addr_in    = 32'h0000_1006;
      do_access(0, 32'hCAFE_F00D, stalls, reqs);
      chk("ld_stalls", stalls, 32'd2);
      chk("ld_req_cycles", reqs, 32'd1);
      chk("ld_data", Data_out, 32'hCAFE_F00D);
      chk("ld_addr", mem_addr, 32'h0000_1004);
      chk("ld_be", {28'd0, mem_be}, 32'hF);
      chk("ld_we", {31'd0, mem_we}, 32'd0);
      chk("ld_req_done", {31'd0, mem_req}, 32'd0);

      // store, ack after 3 wait cycles
      @(negedge clk); #1;
      MemRead_in  = 1'b0;
      MemWrite_in = 1'b1;
      ByteEn_in   = 4'b0011;
      WrData_in   = 32'h1234_5678;
      Addr_in     = 32'h0000_2003;
      do_access(3, 32'hDEAD_BEEF, stalls, reqs);
      chk("st_stalls", stalls, 32'd5);
      chk("st_req_cycles", reqs, 32'd4);
      chk("st_data_hold", Data_out, 32'hCAFE_F00D);
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_be", {28'd0, mem_be}, 32'h3);
      chk("st_wdata", mem_wdata, 32'h1234_5678);
      chk("st_addr", mem_addr, 32'h0000_2000);

      // suppressed store: overflow
      @(negedge clk); #1;
      Overflow_in = 1'b1;
      do_access(0, 32'h0, stalls, reqs);
      chk("ovf_stalls", stalls, 32'd0);
      @(negedge clk); #1;
      @(posedge clk);
      chk("ovf_no_req", {31'd0, mem_req}, 32'd0);

      // suppressed store: no byte lanes
      @(negedge clk); #1;
      Overflow_in = 1'b0;
      ByteEn_in   = 4'b0000;
      do_access(0, 32'h0, stalls, reqs);
      chk("be0_stalls", stalls, 32'd0);
      @(negedge clk); #1;
      @(posedge clk);
      chk("be0_no_req", {31'd0, mem_req}, 32'd0);
      chk("be0_stall", {31'd0, Stall}, 32'd0);

      // load that never gets an ack
      @(negedge clk); #1;
      MemWrite_in = 1'b0;
      MemRead_in  = 1'b1;
      Addr_in     = 32'h0000_3000;
      do_access(-1, 32'h0, stalls, reqs);
      chk("to_stalls", stalls, 32'd17);
      chk("to_req_cycles", reqs, 32'd16);
      chk("to_err", {31'd0, Timeout_err}, 32'd1);
      chk("to_data_zero", Data_out, 32'd0);
      chk("to_req_drop", {31'd0, mem_req}, 32'd0);

      // back-to-back loads
      @(negedge clk); #1;
      Addr_in = 32'h0000_2000;
      do_access(0, 32'h1111_1111, stalls, reqs);
      chk("b2b_a_stalls", stalls, 32'd2);
      chk("b2b_a_data", Data_out, 32'h1111_1111);
      chk("b2b_done_no_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk); #1;
      Addr_in = 32'h0000_200A;
      do_access(0, 32'h2222_2222, stalls, reqs);
      chk("b2b_b_stalls", stalls, 32'd2);
      chk("b2b_b_req_cycles", reqs, 32'd1);
      chk("b2b_b_data", Data_out, 32'h2222_2222);
      chk("b2b_b_addr", mem_addr, 32'h0000_2008);
      chk("to_err_sticky", {31'd0, Timeout_err}, 32'd1);

      // reset during the second REQ cycle, late ack afterwards
      @(negedge clk); #1;
      Addr_in = 32'h0000_4000;
      @(posedge clk);
      chk("rm_idle_stall", {31'd0, Stall}, 32'd1);
      @(negedge clk); #1;
      @(posedge clk);
      chk("rm_req1", {31'd0, mem_req}, 32'd1);
      @(negedge clk); #1;
      Reset = 1'b1;
      @(posedge clk);
      chk("rm_rst_stall", {31'd0, Stall}, 32'd0);
      chk("rm_rst_bubble", {31'd0, MemWb_bubble}, 32'd0);
      @(negedge clk); #1;
      Reset      = 1'b0;
      MemRead_in = 1'b0;
      mem_ack    = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      @(posedge clk);
      chk("rm_req_drop", {31'd0, mem_req}, 32'd0);
      chk("rm_stall", {31'd0, Stall}, 32'd0);
      chk("rm_addr", mem_addr, 32'd0);
      chk("rm_be", {28'd0, mem_be}, 32'd0);
      chk("rm_data", Data_out, 32'd0);
      chk("rm_err_clear", {31'd0, Timeout_err}, 32'd0);
      @(negedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk);
      chk("rm_late_ack_data", Data_out, 32'd0);
      chk("rm_late_ack_req", {31'd0, mem_req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
